// File: rtl/gp10_periph.sv
// Memory-mapped board peripheral: a 16-bit output register shown on LEDs and
// seven-segment displays, plus synchronized, debounced switch input with a change flag.
module gp10_periph #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gp10_memw,
    input  logic        gp10_read_en,
    input  logic [15:0] gp10_dataw,
    output logic [15:0] gp10_datar,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE,
        SETTLING
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       out_reg;
    logic [9:0]        s1_reg, s2_reg;
    logic [9:0]        cand_reg, cand_next;
    logic [9:0]        sw_stable_reg, sw_stable_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              chg_reg, chg_next;
    logic              set_chg;
    logic [6:0]        hex [4];

    // Segment patterns are gfedcba, active-low.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg       <= '0;
            s1_reg        <= '0;
            s2_reg        <= '0;
            state_reg     <= STABLE;
            cand_reg      <= '0;
            cnt_reg       <= '0;
            sw_stable_reg <= '0;
            chg_reg       <= 1'b0;
        end else begin
            if (gp10_memw) begin
                out_reg <= gp10_dataw;
            end
            s1_reg        <= SW;
            s2_reg        <= s1_reg;
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            cnt_reg       <= cnt_next;
            sw_stable_reg <= sw_stable_next;
            chg_reg       <= chg_next;
        end
    end

    // Any movement of the synchronized switches restarts the settle window.
    always_comb begin
        state_next     = state_reg;
        cand_next      = cand_reg;
        cnt_next       = cnt_reg;
        sw_stable_next = sw_stable_reg;
        set_chg        = 1'b0;
        case (state_reg)
            STABLE: begin
                if (s2_reg != sw_stable_reg) begin
                    cand_next  = s2_reg;
                    cnt_next   = '0;
                    state_next = SETTLING;
                end
            end
            SETTLING: begin
                if (s2_reg != cand_reg) begin
                    cand_next = s2_reg;
                    cnt_next  = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    sw_stable_next = cand_reg;
                    state_next     = STABLE;
                    set_chg        = (cand_reg != sw_stable_reg);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = STABLE;
        endcase
        // A new change event outranks a read clearing the flag on the same edge.
        if (set_chg) begin
            chg_next = 1'b1;
        end else if (gp10_read_en) begin
            chg_next = 1'b0;
        end else begin
            chg_next = chg_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hex
            assign hex[gi] = seg7(out_reg[4*gi +: 4]);
        end
    endgenerate

    assign HEX0       = hex[0];
    assign HEX1       = hex[1];
    assign HEX2       = hex[2];
    assign HEX3       = hex[3];
    assign LEDR       = out_reg[9:0];
    assign gp10_datar = {5'b0, chg_reg, sw_stable_reg};

endmodule

// File: tb/tb_gp10_periph.sv
// Bench for gp10_periph: scenario tasks plus a randomized run against a run-length
// debounce model kept alongside the DUT.
module tb_gp10_periph;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        gp10_memw = 1'b0;
    logic        gp10_read_en = 1'b0;
    logic [15:0] gp10_dataw = '0;
    logic [15:0] gp10_datar;
    logic [9:0]  SW = '0;
    logic [9:0]  LEDR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    logic [6:0]  hex_obs [4];

    int n_tests = 0;
    int n_fail  = 0;

    gp10_periph #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .gp10_memw    (gp10_memw),
        .gp10_read_en (gp10_read_en),
        .gp10_dataw   (gp10_dataw),
        .gp10_datar   (gp10_datar),
        .SW           (SW),
        .LEDR         (LEDR),
        .HEX0         (HEX0),
        .HEX1         (HEX1),
        .HEX2         (HEX2),
        .HEX3         (HEX3)
    );

    always #5 clk = ~clk;

    assign hex_obs[0] = HEX0;
    assign hex_obs[1] = HEX1;
    assign hex_obs[2] = HEX2;
    assign hex_obs[3] = HEX3;

    // Reference model: switches reach the debouncer two edges late; a value is
    // accepted once it has been seen on D+1 consecutive edges.
    logic [9:0]  m_d1, m_d2, m_last, m_stable;
    logic        m_chg;
    logic [15:0] m_out;
    int          m_run;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_d1 = '0; m_d2 = '0; m_last = '0; m_stable = '0;
            m_chg = 1'b0; m_out = '0; m_run = D + 2;
        end else begin
            logic [9:0] v;
            logic commit_chg;
            v = m_d2;
            m_d2 = m_d1;
            m_d1 = SW;
            if (v == m_last) begin
                if (m_run < D + 2) m_run = m_run + 1;
            end else begin
                m_last = v;
                m_run = 1;
            end
            commit_chg = (m_run == D + 1) && (v != m_stable);
            if (m_run == D + 1) m_stable = v;
            if (commit_chg) m_chg = 1'b1;
            else if (gp10_read_en) m_chg = 1'b0;
            if (gp10_memw) m_out = gp10_dataw;
        end
    end

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        logic [6:0] tab [16];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tab[v];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (gp10_datar !== 16'h0000 || LEDR !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_data datar=%h ledr=%h required datar=0000 ledr=000", gp10_datar, LEDR);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (hex_obs[i] !== 7'b1000000) begin
                n_fail++;
                $display("FAIL reset_hex%0d got=%b required=1000000", i, hex_obs[i]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step();
        $display("[TB] reset checked");
    endtask

    task automatic test_write_1234();
        gp10_dataw = 16'h1234;
        gp10_memw = 1'b1;
        step();
        gp10_memw = 1'b0;
        gp10_dataw = 16'hFFFF;
        step();
        n_tests++;
        if (LEDR !== 10'h234 || HEX0 !== 7'b0011001 || HEX1 !== 7'b0110000 ||
            HEX2 !== 7'b0100100 || HEX3 !== 7'b1111001) begin
            n_fail++;
            $display("FAIL write_1234 ledr=%h hex=%b_%b_%b_%b required ledr=234 hex=1111001_0100100_0110000_0011001",
                     LEDR, HEX3, HEX2, HEX1, HEX0);
        end
        $display("[TB] write 0x1234 -> ledr=%h", LEDR);
    endtask

    task automatic test_clean_change();
        logic [15:0] exp;
        SW = 10'h2A5;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp = (e < 7) ? 16'h0000 : 16'h06A5;
            n_tests++;
            if (gp10_datar !== exp) begin
                n_fail++;
                $display("FAIL clean_change_edge%0d datar=%h required=%h", e, gp10_datar, exp);
            end
        end
        gp10_read_en = 1'b1;
        step();
        gp10_read_en = 1'b0;
        n_tests++;
        if (gp10_datar !== 16'h02A5) begin
            n_fail++;
            $display("FAIL clean_change_read datar=%h required=02a5", gp10_datar);
        end
        $display("[TB] clean change 0x2A5 -> datar=%h", gp10_datar);
    endtask

    task automatic test_glitch();
        SW = 10'h000;
        repeat (9) step();
        gp10_read_en = 1'b1;
        step();
        gp10_read_en = 1'b0;
        n_tests++;
        if (gp10_datar !== 16'h0000) begin
            n_fail++;
            $display("FAIL glitch_setup datar=%h required=0000", gp10_datar);
        end
        SW = 10'h3FF;
        repeat (2) step();
        SW = 10'h000;
        for (int c = 0; c < 12; c++) begin
            step();
            n_tests++;
            if (gp10_datar !== 16'h0000) begin
                n_fail++;
                $display("FAIL glitch_cycle%0d datar=%h required=0000", c, gp10_datar);
            end
        end
        $display("[TB] glitch 0x3FF x2 -> datar=%h", gp10_datar);
    endtask

    task automatic test_bounce();
        int edge_no, last_change, seen_edge, changes;
        logic [9:0] prev_obs, prev_sw;
        edge_no = 0; last_change = 0; seen_edge = -1; changes = 0;
        prev_obs = gp10_datar[9:0];
        prev_sw = SW;
        for (int c = 0; c < 30; c++) begin
            SW = (c < 10) ? (((c / 2) % 2 == 0) ? 10'h001 : 10'h000) : 10'h001;
            edge_no++;
            if (SW != prev_sw) last_change = edge_no;
            prev_sw = SW;
            step();
            if (gp10_datar[9:0] != prev_obs) begin
                changes++;
                seen_edge = edge_no;
                n_tests++;
                if (gp10_datar[9:0] !== 10'h001) begin
                    n_fail++;
                    $display("FAIL bounce_value stable=%h required=001", gp10_datar[9:0]);
                end
            end
            prev_obs = gp10_datar[9:0];
        end
        n_tests++;
        if (changes != 1 || seen_edge - last_change != 6) begin
            n_fail++;
            $display("FAIL bounce_timing changes=%0d edges_after_last=%0d required changes=1 edges=7",
                     changes, seen_edge - last_change + 1);
        end
        gp10_read_en = 1'b1;
        step();
        gp10_read_en = 1'b0;
        $display("[TB] bounce -> %0d change(s), datar=%h", changes, gp10_datar);
    endtask

    task automatic test_read_collision();
        SW = 10'h155;
        for (int e = 1; e <= 6; e++) step();
        n_tests++;
        if (gp10_datar !== 16'h0001) begin
            n_fail++;
            $display("FAIL collision_pre datar=%h required=0001", gp10_datar);
        end
        gp10_read_en = 1'b1;
        step();
        gp10_read_en = 1'b0;
        n_tests++;
        if (gp10_datar !== 16'h0555) begin
            n_fail++;
            $display("FAIL collision_set_wins datar=%h required=0555", gp10_datar);
        end
        $display("[TB] read on update edge -> datar=%h", gp10_datar);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) SW = 10'($urandom);
            else if ($urandom_range(0, 9) == 0) SW = SW ^ 10'(1 << $urandom_range(0, 9));
            gp10_read_en = ($urandom_range(0, 7) == 0);
            gp10_memw = ($urandom_range(0, 3) == 0);
            gp10_dataw = 16'($urandom);
            step();
            n_tests++;
            if (gp10_datar !== {5'b0, m_chg, m_stable}) begin
                n_fail++;
                $display("FAIL random_datar cycle=%0d datar=%h required=%h", c, gp10_datar, {5'b0, m_chg, m_stable});
            end
            n_tests++;
            if (LEDR !== m_out[9:0]) begin
                n_fail++;
                $display("FAIL random_ledr cycle=%0d ledr=%h required=%h", c, LEDR, m_out[9:0]);
            end
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (hex_obs[i] !== seg_ref(m_out[4*i +: 4])) begin
                    n_fail++;
                    $display("FAIL random_hex%0d cycle=%0d got=%b required=%b", i, c, hex_obs[i], seg_ref(m_out[4*i +: 4]));
                end
            end
        end
        gp10_read_en = 1'b0;
        gp10_memw = 1'b0;
        $display("[TB] random run done, datar=%h ledr=%h", gp10_datar, LEDR);
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        SW = 10'h000;
        repeat (10) step();
        gp10_dataw = 16'hFFFF;
        gp10_memw = 1'b1;
        step();
        gp10_memw = 1'b0;
        SW = 10'h0AB;
        repeat (4) step();
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (gp10_datar !== 16'h0000 || LEDR !== 10'h000 || HEX0 !== 7'b1000000 ||
            HEX1 !== 7'b1000000 || HEX2 !== 7'b1000000 || HEX3 !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_mid datar=%h ledr=%h hex=%b_%b_%b_%b required all reset values",
                     gp10_datar, LEDR, HEX3, HEX2, HEX1, HEX0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp = (e < 7) ? 16'h0000 : 16'h04AB;
            n_tests++;
            if (gp10_datar !== exp) begin
                n_fail++;
                $display("FAIL post_reset_edge%0d datar=%h required=%h", e, gp10_datar, exp);
            end
        end
        $display("[TB] reset mid-settle then 0x0AB -> datar=%h", gp10_datar);
    endtask

    initial begin
        test_reset();
        test_write_1234();
        test_clean_change();
        test_glitch();
        test_bounce();
        test_read_collision();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
